card_dealer: RTL
================

CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter WIDTH, default 12, giving the seed input width; legal range 1..12.
REQ-002 SHALL have port clk_50M  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port i_RstCounter  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_Seed  input  WIDTH  free-running count value used as the random seed.
REQ-005 SHALL have port i_SeedLoad  input  1  one-cycle pulse that loads the seed and refills the deck.
REQ-006 SHALL have port i_DrawReq  input  1  one-cycle pulse that requests one card.
REQ-007 SHALL have port i_TwoSec  input  1  high when the external 2 s display timer has expired.
REQ-008 SHALL have port o_Card  output  4  last dealt card value, 1..13.
REQ-009 SHALL have port o_CardValid  output  1  one-cycle strobe marking a new o_Card.
REQ-010 SHALL have port o_Busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port o_DeckEmpty  output  1  high while the cards-left count is 0.
REQ-012 SHALL have port o_CardsLeft  output  6  cards remaining in the deck, 0..52.
REQ-013 SHALL have port o_ActTimer  output  1  run-enable for the external 2 s timer.
REQ-014 SHALL have port o_ClrTimer  output  1  one-cycle clear pulse for the external 2 s timer.

Function
REQ-015 SHALL hold a 16-bit LFSR.
- Each cycle: shift left; new bit0 = b15^b13^b12^b10.
- Exception: no shift on a cycle where a seed load occurs.
REQ-016 SHALL, on an accepted seed load, set LFSR = 16'hA000 OR zero-extended i_Seed, which is always nonzero.
REQ-017 SHALL hold a 3-bit remaining-count per card value 1..13, each refilled to 4 on reset and on an accepted seed load.
REQ-018 SHALL keep o_CardsLeft equal to the sum of the 13 remaining-counts; refill sets it to 52.
REQ-019 SHALL implement an FSM with states IDLE, DRAW, PRESENT, WAIT2S and CLEAR.
REQ-020 SHALL accept i_SeedLoad only in IDLE; in other states it is ignored.
REQ-021 SHALL, in IDLE with i_DrawReq=1 and o_CardsLeft>0, go to DRAW.
- i_DrawReq is ignored when o_CardsLeft=0.
- i_DrawReq is ignored in every state other than IDLE.
REQ-022 SHALL, in IDLE, give i_SeedLoad priority when i_SeedLoad and i_DrawReq are both high: seed load done, draw dropped.
REQ-023 SHALL, in DRAW, take candidate c = current LFSR[3:0] each cycle.
- Accept c if 1<=c<=13 and remaining[c]>0.
- On accept: decrement remaining[c] and o_CardsLeft, latch o_Card=c, go to PRESENT.
- On reject: stay in DRAW; the LFSR advances per REQ-015.
REQ-024 SHALL drive o_CardValid=1 for exactly the one cycle in PRESENT, then go to WAIT2S.
REQ-025 SHALL hold o_ActTimer=1 throughout WAIT2S and go to CLEAR on the first cycle with i_TwoSec=1.
REQ-026 SHALL drive o_ClrTimer=1 for exactly the one cycle in CLEAR, then go to IDLE.
REQ-027 SHALL hold o_Card stable from PRESENT until the next accept.
REQ-028 SHALL give a minimum request-to-strobe latency of 2 cycles: IDLE->DRAW, then accept on the first DRAW cycle.

Reset
REQ-029 SHALL, while i_RstCounter=1, asynchronously force the following:
- state=IDLE, LFSR=16'hACE1;
- deck refilled, o_CardsLeft=52;
- o_Card=0, o_CardValid=0, o_Busy=0, o_DeckEmpty=0, o_ActTimer=0, o_ClrTimer=0.
REQ-030 SHALL, on reset during any state (mid-draw or mid-wait), abandon that operation with no partial decrement retained and no o_ClrTimer pulse.

Verification
REQ-031 SHALL cover: assert reset -> all outputs at REQ-029 values; o_CardsLeft=52.
REQ-032 SHALL cover: i_SeedLoad with i_Seed=12'h000, then i_DrawReq -> LFSR=16'hA000 after load; one o_CardValid with o_Card in 1..13; o_CardsLeft=51; o_ActTimer=1 until i_TwoSec; then one o_ClrTimer pulse; then o_Busy=0.
REQ-033 SHALL cover: 52 draws with i_TwoSec tied high -> each value 1..13 dealt exactly 4 times; o_DeckEmpty=1; 53rd i_DrawReq gives no o_CardValid and o_Busy stays 0.
REQ-034 SHALL cover: i_SeedLoad and i_DrawReq in the same IDLE cycle -> deck refilled to 52; no draw started; o_Busy=0.
REQ-035 SHALL cover: i_DrawReq and i_SeedLoad pulsed during WAIT2S -> both ignored; o_CardsLeft unchanged.
REQ-036 SHALL cover: reset asserted in WAIT2S after the first card -> o_ActTimer drops immediately; o_CardsLeft=52; no o_ClrTimer pulse.

Source files
------------

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - 52-card dealer with LFSR draw, per-value deck counts and 2 s display handshake
module card_dealer #(
    parameter int WIDTH = 12
) (
    input  logic             clk_50M,
    input  logic             i_RstCounter,
    input  logic [WIDTH-1:0] i_Seed,
    input  logic             i_SeedLoad,
    input  logic             i_DrawReq,
    input  logic             i_TwoSec,
    output logic [3:0]       o_Card,
    output logic             o_CardValid,
    output logic             o_Busy,
    output logic             o_DeckEmpty,
    output logic [5:0]       o_CardsLeft,
    output logic             o_ActTimer,
    output logic             o_ClrTimer
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAW    = 3'd1,
        S_PRESENT = 3'd2,
        S_WAIT2S  = 3'd3,
        S_CLEAR   = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_RESET = 16'hACE1;
    localparam logic [15:0] SEED_BASE  = 16'hA000;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_shift;
    logic [15:0] seed_ext;
    // Indexed directly by the 4-bit candidate; slots 0, 14 and 15 stay at 0 so
    // an out-of-range candidate can never look available.
    logic [2:0]  remaining [16];
    logic [5:0]  cards_left;
    logic [3:0]  cand;
    logic        cand_ok;
    logic        seed_accept;
    logic        draw_accept;

    assign seed_ext   = {{(16 - WIDTH){1'b0}}, i_Seed};
    assign lfsr_shift = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign cand       = lfsr[3:0];
    assign cand_ok    = (cand != 4'd0) && (cand <= 4'd13) && (remaining[cand] != 3'd0);

    // State register
    always_ff @(posedge clk_50M or posedge i_RstCounter) begin
        if (i_RstCounter) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, accept strobes and state-decoded outputs
    always_comb begin
        state_nxt   = state;
        seed_accept = 1'b0;
        draw_accept = 1'b0;
        o_CardValid = 1'b0;
        o_Busy      = 1'b1;
        o_ActTimer  = 1'b0;
        o_ClrTimer  = 1'b0;
        case (state)
            S_IDLE: begin
                o_Busy = 1'b0;
                if (i_SeedLoad) begin
                    seed_accept = 1'b1;
                end else if (i_DrawReq && (cards_left != 6'd0)) begin
                    state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                if (cand_ok) begin
                    draw_accept = 1'b1;
                    state_nxt   = S_PRESENT;
                end
            end
            S_PRESENT: begin
                o_CardValid = 1'b1;
                state_nxt   = S_WAIT2S;
            end
            S_WAIT2S: begin
                o_ActTimer = 1'b1;
                if (i_TwoSec) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                o_ClrTimer = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // LFSR free-runs every cycle except the one in which a seed is loaded
    always_ff @(posedge clk_50M or posedge i_RstCounter) begin
        if (i_RstCounter) begin
            lfsr <= LFSR_RESET;
        end else if (seed_accept) begin
            lfsr <= SEED_BASE | seed_ext;
        end else begin
            lfsr <= lfsr_shift;
        end
    end

    // Per-value counts: refill on reset or seed load, decrement the accepted value
    always_ff @(posedge clk_50M or posedge i_RstCounter) begin
        if (i_RstCounter) begin
            for (int i = 0; i < 16; i++) begin
                remaining[i] <= ((i >= 1) && (i <= 13)) ? 3'd4 : 3'd0;
            end
        end else if (seed_accept) begin
            for (int i = 0; i < 16; i++) begin
                remaining[i] <= ((i >= 1) && (i <= 13)) ? 3'd4 : 3'd0;
            end
        end else if (draw_accept) begin
            remaining[cand] <= remaining[cand] - 3'd1;
        end
    end

    // Running total kept alongside the per-value counts so it is never summed
    always_ff @(posedge clk_50M or posedge i_RstCounter) begin
        if (i_RstCounter) begin
            cards_left <= 6'd52;
        end else if (seed_accept) begin
            cards_left <= 6'd52;
        end else if (draw_accept) begin
            cards_left <= cards_left - 6'd1;
        end
    end

    // Dealt card is held until the next accepted candidate
    always_ff @(posedge clk_50M or posedge i_RstCounter) begin
        if (i_RstCounter) begin
            o_Card <= 4'd0;
        end else if (draw_accept) begin
            o_Card <= cand;
        end
    end

    assign o_CardsLeft = cards_left;
    assign o_DeckEmpty = (cards_left == 6'd0);

endmodule
